// File: rtl/traffic_ctrl_timed.sv
// traffic_ctrl_timed: highway/farm-road intersection controller.
// Six-state Moore machine with a saturating dwell counter that times every
// phase in clk cycles, plus minimum-green for both roads, a farm-road
// maximum-green timeout and an all-red phase on each side of the farm green.
// All outputs are registered; phase, lamps and walk change on the same edge.
// Optional feature macro: TRAFFIC_PED_EN (adds ped_req / ped_walk).
module traffic_ctrl_timed #(
    parameter int CNT_W          = 8,
    parameter int Y2R_DELAY      = 3,
    parameter int R2G_DELAY      = 2,
    parameter int HWY_MIN_GREEN  = 8,
    parameter int FARM_MIN_GREEN = 4,
    parameter int FARM_MAX_GREEN = 16
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       x,
`ifdef TRAFFIC_PED_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic [1:0] highway,
    output logic [1:0] farm,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HWY_GREEN   = 3'd0,
        HWY_YELLOW  = 3'd1,
        ALL_RED_A   = 3'd2,
        FARM_GREEN  = 3'd3,
        FARM_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    // Delays are truncated to the counter width first, then turned into the
    // last dwell value of each interval (dwell starts at 0 on state entry).
    localparam logic [CNT_W-1:0] ONE           = CNT_W'(1);
    localparam logic [CNT_W-1:0] Y2R_LAST      = CNT_W'(Y2R_DELAY) - ONE;
    localparam logic [CNT_W-1:0] R2G_LAST      = CNT_W'(R2G_DELAY) - ONE;
    localparam logic [CNT_W-1:0] HWY_MIN_LAST  = CNT_W'(HWY_MIN_GREEN) - ONE;
    localparam logic [CNT_W-1:0] FARM_MIN_LAST = CNT_W'(FARM_MIN_GREEN) - ONE;
    localparam logic [CNT_W-1:0] FARM_MAX_LAST = CNT_W'(FARM_MAX_GREEN) - ONE;

    // The state register is kept as plain bits so that the unused codes 6 and
    // 7 remain representable and can be steered back to the highway green.
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       hwy_q, hwy_d;
    logic [1:0]       farm_q, farm_d;
    logic             req;

`ifdef TRAFFIC_PED_EN
    logic ped_pend_q, ped_pend_d;
    logic ped_walk_q, ped_walk_d;

    assign req = x | ped_pend_q;
`else
    assign req = x;
`endif

    // Next-state logic: timed exits per phase, illegal codes recover to S0.
    // With a pending pedestrian and x already low, the farm green still runs
    // to its minimum because the minimum term below gates the early exit.
    always_comb begin
        state_d = HWY_GREEN;
        case (state_q)
            HWY_GREEN:
                state_d = (req && (dwell_q >= HWY_MIN_LAST)) ? HWY_YELLOW : HWY_GREEN;
            HWY_YELLOW:
                state_d = (dwell_q == Y2R_LAST) ? ALL_RED_A : HWY_YELLOW;
            ALL_RED_A:
                state_d = (dwell_q == R2G_LAST) ? FARM_GREEN : ALL_RED_A;
            FARM_GREEN:
                state_d = ((!x && (dwell_q >= FARM_MIN_LAST)) || (dwell_q == FARM_MAX_LAST))
                          ? FARM_YELLOW : FARM_GREEN;
            FARM_YELLOW:
                state_d = (dwell_q == Y2R_LAST) ? ALL_RED_B : FARM_YELLOW;
            ALL_RED_B:
                state_d = (dwell_q == R2G_LAST) ? HWY_GREEN : ALL_RED_B;
            default:
                state_d = HWY_GREEN;
        endcase
    end

    // Dwell counter restarts on any state change and otherwise saturates.
    always_comb begin
        dwell_d = '0;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (&dwell_q) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + ONE;
        end
    end

    // Lamp decode from the next state so lamps register together with phase.
    always_comb begin
        hwy_d  = LAMP_GREEN;
        farm_d = LAMP_RED;
        case (state_d)
            HWY_YELLOW:  begin hwy_d = LAMP_YELLOW; farm_d = LAMP_RED;    end
            ALL_RED_A:   begin hwy_d = LAMP_RED;    farm_d = LAMP_RED;    end
            FARM_GREEN:  begin hwy_d = LAMP_RED;    farm_d = LAMP_GREEN;  end
            FARM_YELLOW: begin hwy_d = LAMP_RED;    farm_d = LAMP_YELLOW; end
            ALL_RED_B:   begin hwy_d = LAMP_RED;    farm_d = LAMP_RED;    end
            default:     begin hwy_d = LAMP_GREEN;  farm_d = LAMP_RED;    end
        endcase
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian request is remembered outside the farm green and consumed on
    // entry to it; walk is shown for exactly the farm green phase.
    always_comb begin
        ped_pend_d = ped_pend_q;
        ped_walk_d = (state_d == FARM_GREEN);
        if ((state_d == FARM_GREEN) && (state_q != FARM_GREEN)) begin
            ped_pend_d = 1'b0;
        end else if ((state_q != FARM_GREEN) && ped_req) begin
            ped_pend_d = 1'b1;
        end
    end

    // Pedestrian registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            ped_pend_q <= 1'b0;
            ped_walk_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            ped_walk_q <= ped_walk_d;
        end
    end

    assign ped_walk = ped_walk_q;
`endif

    // State, dwell and lamp registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= HWY_GREEN;
            dwell_q <= '0;
            hwy_q   <= LAMP_GREEN;
            farm_q  <= LAMP_RED;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            hwy_q   <= hwy_d;
            farm_q  <= farm_d;
        end
    end

    assign phase   = state_q;
    assign highway = hwy_q;
    assign farm    = farm_q;

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// tb_traffic_ctrl_timed: scoreboard bench for traffic_ctrl_timed at default
// parameters. Expected {phase, highway, farm} words are derived from the
// nominal phase durations and pushed when each cycle's stimulus is driven,
// then popped and compared one cycle later.
// Build with TRAFFIC_PED_EN defined to also exercise the pedestrian feature.
module tb_traffic_ctrl_timed;

    logic       clk = 1'b0;
    logic       clear_n;
    logic       x;
`ifdef TRAFFIC_PED_EN
    logic       ped_req;
    logic       ped_walk;
`endif
    logic [1:0] highway;
    logic [1:0] farm;
    logic [2:0] phase;

    int         assertCount = 0;
    int         failCount   = 0;
    logic [6:0] expQ[$];
    logic [6:0] expV;
    logic [6:0] actV;

    traffic_ctrl_timed dut (
        .clk     (clk),
        .clear_n (clear_n),
        .x       (x),
`ifdef TRAFFIC_PED_EN
        .ped_req (ped_req),
        .ped_walk(ped_walk),
`endif
        .highway (highway),
        .farm    (farm),
        .phase   (phase)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Expected output word for a phase code: {phase, highway lamp, farm lamp}.
    function automatic logic [6:0] expOf(input int ph);
        logic [1:0] h;
        logic [1:0] f;
        case (ph)
            1:       begin h = 2'd1; f = 2'd0; end
            2, 5:    begin h = 2'd0; f = 2'd0; end
            3:       begin h = 2'd0; f = 2'd2; end
            4:       begin h = 2'd0; f = 2'd1; end
            default: begin h = 2'd2; f = 2'd0; end
        endcase
        return {3'(ph), h, f};
    endfunction

    // Phase expected i cycles after a fresh S0 entry, given the farm green
    // length; without looping, the controller parks in S0 after one cycle.
    function automatic int seqPhase(input int i, input int farmLen, input bit loopOn);
        int d[6];
        int k;
        int total;
        d = '{8, 3, 2, farmLen, 3, 2};
        total = 18 + farmLen;
        if (!loopOn && i >= total) return 0;
        k = i % total;
        for (int s = 0; s < 6; s++) begin
            if (k < d[s]) return s;
            k -= d[s];
        end
        return 0;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        expQ.delete();
        x       = 1'b1;
        clear_n = 1'b0;
        tick;
        expQ.push_back(expOf(0));
        tick;
        expV = expQ.pop_front();
        actV = {phase, highway, farm};
        assertCount++;
        if (actV !== expV) begin
            $display("[TB] FAIL reset_outputs: got %b, wanted %b", actV, expV);
            failCount++;
        end
        assertCount++;
        if (dut.dwell_q !== 8'd0) begin
            $display("[TB] FAIL reset_dwell: got %0d, wanted 0", dut.dwell_q);
            failCount++;
        end
`ifdef TRAFFIC_PED_EN
        assertCount++;
        if (ped_walk !== 1'b0) begin
            $display("[TB] FAIL reset_walk: got %b, wanted 0", ped_walk);
            failCount++;
        end
`endif
    endtask

    task automatic test_idle;
        expQ.delete();
        x       = 1'b0;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL idle cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            expQ.push_back(expOf(0));
            tick;
        end
    endtask

    task automatic test_timeout_loop;
        expQ.delete();
        x       = 1'b1;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL timeout_loop cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            expQ.push_back(expOf(seqPhase(i + 1, 16, 1'b1)));
            tick;
        end
    endtask

    task automatic test_min_farm;
        expQ.delete();
        x       = 1'b1;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL min_farm cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            x = (i < 15);
            expQ.push_back(expOf(seqPhase(i + 1, 4, 1'b0)));
            tick;
        end
    endtask

    task automatic test_pulse_and_late_req;
        expQ.delete();
        x       = 1'b0;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 27; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL pulse_late_req cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            x = ((i >= 2) && (i <= 4)) || (i >= 20);
            expQ.push_back(expOf((i + 1 <= 20) ? 0 : seqPhase(i + 1 - 13, 16, 1'b1)));
            tick;
        end
    endtask

    task automatic test_reset_mid_yellow;
        expQ.delete();
        x       = 1'b1;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL reset_mid_yellow cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            if (i == 31) begin
                assertCount++;
                if (dut.dwell_q !== 8'd0) begin
                    $display("[TB] FAIL reset_mid_yellow_dwell: got %0d, wanted 0", dut.dwell_q);
                    failCount++;
                end
            end
            clear_n = (i != 30);
            expQ.push_back(expOf((i + 1 <= 30) ? seqPhase(i + 1, 16, 1'b1)
                                                : seqPhase(i + 1 - 31, 16, 1'b1)));
            tick;
        end
        clear_n = 1'b1;
    endtask

    task automatic test_illegal_state;
        expQ.delete();
        x       = 1'b1;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL illegal_state cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            if (i == 14) begin
                force dut.state_q = 3'd6;
                #1;
                release dut.state_q;
            end
            expQ.push_back(expOf((i + 1 <= 14) ? seqPhase(i + 1, 16, 1'b1)
                                                : seqPhase(i + 1 - 15, 16, 1'b1)));
            tick;
        end
    endtask

`ifdef TRAFFIC_PED_EN
    task automatic test_ped;
        expQ.delete();
        x       = 1'b0;
        ped_req = 1'b0;
        clear_n = 1'b0;
        expQ.push_back(expOf(0));
        tick;
        clear_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            expV = expQ.pop_front();
            actV = {phase, highway, farm};
            assertCount++;
            if (actV !== expV) begin
                $display("[TB] FAIL ped cycle %0d: got %b, wanted %b", i, actV, expV);
                failCount++;
            end
            assertCount++;
            if (ped_walk !== (seqPhase(i, 4, 1'b0) == 3)) begin
                $display("[TB] FAIL ped_walk cycle %0d: got %b, wanted %b",
                         i, ped_walk, (seqPhase(i, 4, 1'b0) == 3));
                failCount++;
            end
            ped_req = (i == 2);
            expQ.push_back(expOf(seqPhase(i + 1, 4, 1'b0)));
            tick;
        end
        ped_req = 1'b0;
    endtask
`endif

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        x       = 1'b0;
        clear_n = 1'b0;
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b0;
`endif
        test_reset;
        test_idle;
        test_timeout_loop;
        test_min_farm;
        test_pulse_and_late_req;
        test_reset_mid_yellow;
        test_illegal_state;
`ifdef TRAFFIC_PED_EN
        test_ped;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
